// File: rtl/ds_adc_decim.sv
// Purpose: multi-channel delta-sigma decimator; counts comparator ones over an osr window, emits bipolar samples per channel.
// Latency: out_valid rises 1 clk after the last bit of a window; drain streams channels 0..NCH-1, one beat per accepted cycle.
// Backpressure: out_ready stalls the drain; a window ending mid-drain is dropped and sets sticky overrun.
// Option: DS_ADC_DECIM_SAT_EN clamps out_data to the signed WIDTH range; otherwise the sample wraps.
module ds_adc_decim #(
  parameter int NCH   = 2,
  parameter int WIDTH = 8,
  parameter int OSR_W = 8,
  // derived from NCH; leave at default
  parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic [OSR_W-1:0]       osr,
  input  logic [NCH-1:0]         comp_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [CH_W-1:0]        out_chan,
  output logic                   out_last,
  output logic                   overrun
);

  localparam int CW = OSR_W + 1;                   // count range 0..osr_eff, no wrap
  localparam int SW = OSR_W + 2;                   // signed conversion width
  localparam int EW = (SW > WIDTH) ? SW : WIDTH;   // common width for range handling

  typedef enum logic {W_IDLE, W_INTEG} win_state_t;
  typedef enum logic {O_IDLE, O_SEND}  out_state_t;

  win_state_t             win_state, win_state_nxt;
  out_state_t             out_state, out_state_nxt;
  logic [OSR_W-1:0]       osr_eff, osr_eff_nxt;
  logic [OSR_W-1:0]       phase, phase_nxt;
  logic [OSR_W-1:0]       osr_clamp;
  logic [CW-1:0]          cnt     [NCH];
  logic [CW-1:0]          cnt_nxt [NCH];
  logic [CW-1:0]          cnt_inc [NCH];
  logic signed [SW-1:0]   samp    [NCH];
  logic signed [EW-1:0]   sext    [NCH];
  logic [WIDTH-1:0]       conv    [NCH];
  logic [WIDTH-1:0]       hold    [NCH];
  logic [CH_W-1:0]        chan, chan_nxt;
  logic                   load_hold;
  logic                   win_end, accept, last_acc, busy, snap_take, snap_drop;

`ifdef DS_ADC_DECIM_SAT_EN
  localparam int SAT_MAX = (1 << (WIDTH - 1)) - 1;
  localparam logic signed [EW-1:0] SAT_HI = EW'(SAT_MAX);
  localparam logic signed [EW-1:0] SAT_LO = EW'(-SAT_MAX - 1);
`endif

  // window bookkeeping and handshake qualifiers
  always_comb begin
    osr_clamp = (osr < OSR_W'(2)) ? OSR_W'(2) : osr;
    for (int i = 0; i < NCH; i++) begin
      cnt_inc[i] = cnt[i] + CW'(comp_out[i]);
    end
    win_end   = (win_state == W_INTEG) && en && (phase == osr_eff - OSR_W'(1));
    accept    = out_valid && out_ready;
    last_acc  = accept && out_last;
    // a drain whose final beat is accepted this cycle frees the hold registers
    busy      = (out_state == O_SEND) && !last_acc;
    snap_take = win_end && !busy;
    snap_drop = win_end && busy;
  end

  // count-to-sample conversion, including the bit of the window's last cycle
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      samp[i] = $signed({1'b0, cnt_inc[i]}) - $signed({2'b00, osr_eff >> 1});
      sext[i] = EW'(samp[i]);
`ifdef DS_ADC_DECIM_SAT_EN
      if (sext[i] > SAT_HI) begin
        conv[i] = WIDTH'(SAT_HI);
      end else if (sext[i] < SAT_LO) begin
        conv[i] = WIDTH'(SAT_LO);
      end else begin
        conv[i] = WIDTH'(sext[i]);
      end
`else
      conv[i] = WIDTH'(sext[i]);
`endif
    end
  end

  // window FSM next state: start, integrate, back-to-back restart, abort
  always_comb begin
    win_state_nxt = win_state;
    osr_eff_nxt   = osr_eff;
    phase_nxt     = phase;
    cnt_nxt       = cnt;
    case (win_state)
      W_IDLE: begin
        if (en) begin
          win_state_nxt = W_INTEG;
          osr_eff_nxt   = osr_clamp;
          phase_nxt     = '0;
          for (int i = 0; i < NCH; i++) cnt_nxt[i] = '0;
        end
      end
      W_INTEG: begin
        if (!en) begin
          win_state_nxt = W_IDLE;
          phase_nxt     = '0;
          for (int i = 0; i < NCH; i++) cnt_nxt[i] = '0;
        end else if (win_end) begin
          osr_eff_nxt = osr_clamp;
          phase_nxt   = '0;
          for (int i = 0; i < NCH; i++) cnt_nxt[i] = '0;
        end else begin
          phase_nxt = phase + OSR_W'(1);
          cnt_nxt   = cnt_inc;
        end
      end
      default: win_state_nxt = W_IDLE;
    endcase
  end

  // window FSM state, ratio, phase and channel counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_state <= W_IDLE;
      osr_eff   <= '0;
      phase     <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      win_state <= win_state_nxt;
      osr_eff   <= osr_eff_nxt;
      phase     <= phase_nxt;
      cnt       <= cnt_nxt;
    end
  end

  // output FSM next state: snapshot starts a drain, accepted beats advance it
  always_comb begin
    out_state_nxt = out_state;
    chan_nxt      = chan;
    load_hold     = 1'b0;
    case (out_state)
      O_IDLE: begin
        if (snap_take) begin
          out_state_nxt = O_SEND;
          chan_nxt      = '0;
          load_hold     = 1'b1;
        end
      end
      O_SEND: begin
        if (snap_take) begin
          // final beat accepted in the same cycle a window ends: restart at channel 0
          chan_nxt  = '0;
          load_hold = 1'b1;
        end else if (accept) begin
          if (out_last) begin
            out_state_nxt = O_IDLE;
            chan_nxt      = '0;
          end else begin
            chan_nxt = chan + CH_W'(1);
          end
        end
      end
      default: out_state_nxt = O_IDLE;
    endcase
  end

  // output FSM state and channel pointer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_state <= O_IDLE;
      chan      <= '0;
    end else begin
      out_state <= out_state_nxt;
      chan      <= chan_nxt;
    end
  end

  // hold registers keep the snapshot stable for the whole drain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) hold[i] <= '0;
    end else if (load_hold) begin
      for (int i = 0; i < NCH; i++) hold[i] <= conv[i];
    end
  end

  // sticky flag for a window result discarded because a drain was pending
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun <= 1'b0;
    end else if (snap_drop) begin
      overrun <= 1'b1;
    end
  end

  // outputs decode registered state only, so out_valid never depends on out_ready
  always_comb begin
    out_valid = (out_state == O_SEND);
    out_chan  = chan;
    out_data  = hold[chan];
    out_last  = (out_state == O_SEND) && (chan == CH_W'(NCH - 1));
  end

endmodule

// File: tb/tb_ds_adc_decim.sv
`timescale 1ns/1ps
// Directed bench for ds_adc_decim: a default-width instance plus a WIDTH=6 instance for range handling.
module tb_ds_adc_decim;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] osr = 8'd0;
  logic [1:0] comp_out = 2'b00;

  logic       out_valid, out_last, overrun;
  logic [7:0] out_data;
  logic [0:0] out_chan;
  logic       out_valid6, out_last6, overrun6;
  logic [5:0] out_data6;
  logic [0:0] out_chan6;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int q_chan[$];
  int q_data[$];
  int q_last[$];
  int q_cyc[$];
  int e2_data[6] = '{2, -5, 2, -5, 1, -5};

`ifdef DS_ADC_DECIM_SAT_EN
  localparam int E8_HI = 127;
  localparam int E6_HI = 31;
  localparam int E6_LO = -32;
`else
  localparam int E8_HI = -128;
  localparam int E6_HI = 0;
  localparam int E6_LO = 1;
`endif

  ds_adc_decim #(.NCH(2), .WIDTH(8), .OSR_W(8)) u_dut (
    .clk(clk), .rstn(rstn), .en(en), .osr(osr), .comp_out(comp_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .out_last(out_last), .overrun(overrun)
  );

  ds_adc_decim #(.NCH(2), .WIDTH(6), .OSR_W(8)) u_dut6 (
    .clk(clk), .rstn(rstn), .en(en), .osr(osr), .comp_out(comp_out),
    .out_valid(out_valid6), .out_ready(out_ready), .out_data(out_data6),
    .out_chan(out_chan6), .out_last(out_last6), .overrun(overrun6)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // record every beat that will be accepted at the coming rising edge
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      q_chan.push_back(int'(out_chan));
      q_data.push_back(int'($signed(out_data)));
      q_last.push_back(int'(out_last));
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    en = 1'b0;
    out_ready = 1'b0;
    comp_out = 2'b00;
    osr = 8'd0;
    tick(2);
    rstn = 1'b1;
    q_chan.delete();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    tick(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    bit found;

    // reset values
    #12;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_chan", int'(out_chan), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_overrun", int'(overrun), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    tick(1);

    // osr=100, ch0 ones, ch1 zeros
    osr = 8'd100; comp_out = 2'b01; out_ready = 1'b1; en = 1'b1;
    k = 0; found = 1'b0;
    while (k < 200 && !found) begin
      tick(1);
      k++;
      if (out_valid) found = 1'b1;
    end
    chk("t1_latency", k, 101);
    chk("t1_chan0", int'(out_chan), 0);
    chk("t1_data0", int'($signed(out_data)), 50);
    chk("t1_last0", int'(out_last), 0);
    tick(1);
    chk("t1_chan1", int'(out_chan), 1);
    chk("t1_data1", int'($signed(out_data)), -50);
    chk("t1_last1", int'(out_last), 1);
    tick(1);
    chk("t1_idle", int'(out_valid), 0);

    // osr=10, ch0 pattern 1,1,0: window counts 7,7,6
    do_reset();
    osr = 8'd10; out_ready = 1'b1; en = 1'b1; comp_out = 2'b00;
    for (int i = 0; i < 34; i++) begin
      tick(1);
      comp_out = {1'b0, (i % 3 != 2)};
    end
    en = 1'b0;
    chk("t2_nbeats", q_data.size(), 6);
    for (int i = 0; i < 6 && i < q_data.size(); i++) begin
      chk($sformatf("t2_data%0d", i), q_data[i], e2_data[i]);
      chk($sformatf("t2_chan%0d", i), q_chan[i], i % 2);
    end
    if (q_cyc.size() >= 5) begin
      chk("t2_beat_gap", q_cyc[1] - q_cyc[0], 1);
      chk("t2_win_gap1", q_cyc[2] - q_cyc[0], 10);
      chk("t2_win_gap2", q_cyc[4] - q_cyc[2], 10);
    end

    // osr=4, out_ready low for two windows: second window dropped
    do_reset();
    osr = 8'd4; out_ready = 1'b0; comp_out = 2'b11; en = 1'b1;
    tick(5);
    comp_out = 2'b00;
    tick(5);
    chk("t3_valid_held", int'(out_valid), 1);
    chk("t3_overrun", int'(overrun), 1);
    chk("t3_chan_held", int'(out_chan), 0);
    chk("t3_data_held", int'($signed(out_data)), 2);
    en = 1'b0; out_ready = 1'b1;
    tick(3);
    chk("t3_nbeats", q_data.size(), 2);
    if (q_data.size() >= 2) begin
      chk("t3_data0", q_data[0], 2);
      chk("t3_data1", q_data[1], 2);
      chk("t3_last1", q_last[1], 1);
    end
    chk("t3_drained", int'(out_valid), 0);
    chk("t3_sticky", int'(overrun), 1);

    // abort at phase 37, then a fresh window counts from zero
    do_reset();
    osr = 8'd100; comp_out = 2'b11; out_ready = 1'b1; en = 1'b1;
    tick(38);
    en = 1'b0;
    tick(150);
    chk("t4_no_beats", q_data.size(), 0);
    chk("t4_no_valid", int'(out_valid), 0);
    osr = 8'd10; en = 1'b1;
    tick(11);
    chk("t4_valid", int'(out_valid), 1);
    chk("t4_data0", int'($signed(out_data)), 5);
    tick(1);
    chk("t4_data1", int'($signed(out_data)), 5);
    en = 1'b0;

    // osr=0 clamps to 2-cycle windows; drain overlaps the next window end
    do_reset();
    osr = 8'd0; comp_out = 2'b11; out_ready = 1'b1; en = 1'b1;
    tick(3);
    chk("t5_latency", int'(out_valid), 1);
    tick(7);
    chk("t5_nbeats", q_data.size(), 7);
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      chk($sformatf("t5_data%0d", i), q_data[i], 1);
      chk($sformatf("t5_chan%0d", i), q_chan[i], i % 2);
    end
    if (q_cyc.size() >= 4) chk("t5_continuous", q_cyc[3] - q_cyc[0], 3);
    chk("t5_no_overrun", int'(overrun), 0);
    // asynchronous reset mid-drain
    rstn = 1'b0;
    #1;
    chk("t5_rst_valid", int'(out_valid), 0);
    chk("t5_rst_data", int'(out_data), 0);
    chk("t5_rst_chan", int'(out_chan), 0);

    // osr=1 behaves like osr=2
    do_reset();
    osr = 8'd1; comp_out = 2'b11; out_ready = 1'b1; en = 1'b1;
    tick(3);
    chk("t5b_valid", int'(out_valid), 1);
    chk("t5b_data", int'($signed(out_data)), 1);

    // osr=255: +128 on ch0 and -127 on ch1 exceed the 6-bit range
    do_reset();
    osr = 8'd255; comp_out = 2'b01; out_ready = 1'b0; en = 1'b1;
    tick(256);
    chk("t6_valid8", int'(out_valid), 1);
    chk("t6_valid6", int'(out_valid6), 1);
    chk("t6_data8_ch0", int'($signed(out_data)), E8_HI);
    chk("t6_data6_ch0", int'($signed(out_data6)), E6_HI);
    out_ready = 1'b1; en = 1'b0;
    tick(1);
    chk("t6_chan6", int'(out_chan6), 1);
    chk("t6_last6", int'(out_last6), 1);
    chk("t6_data8_ch1", int'($signed(out_data)), -127);
    chk("t6_data6_ch1", int'($signed(out_data6)), E6_LO);
    chk("t6_overrun6", int'(overrun6), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ds_adc_decim.md
# ds_adc_decim

Multi-channel digital back-end for the delta-sigma ADC model. It counts the comparator bitstreams of NCH modulators over a programmable oversampling window and converts each count to a bipolar signed sample. Results are streamed channel-by-channel on a valid/ready output. The block runs entirely in the oversampling clock domain: the slow conversion clock is replaced by an internal window counter, and downstream rate adaptation is the consumer's job.

## Interface
- NCH, 2, number of modulator channels (1..16)
- WIDTH, 8, signed output sample width
- OSR_W, 8, width of the oversampling-ratio input
- CH_W, $clog2(NCH) (min 1), channel index width (derived)

- clk  in  1  oversampling clock, single clock domain
- rstn  in  1  asynchronous active-low reset, applied to all flops
- en  in  1  conversion enable; windows run while high
- osr  in  OSR_W  oversampling ratio, sampled at each window start
- comp_out  in  NCH  comparator bit per channel, sampled every clk
- out_valid  out  1  sample beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  WIDTH  signed sample
- out_chan  out  CH_W  channel index of beat
- out_last  out  1  beat carries channel NCH-1
- overrun  out  1  sticky: a window result was dropped; cleared only by reset

## Operation
- Window FSM: IDLE -> INTEG.
  - IDLE -> INTEG when en=1. Latch osr_eff = max(osr, 2) and clear phase and all channel counters.
  - INTEG: each cycle, phase increments and cnt[i] += comp_out[i].
  - When phase = osr_eff-1, the window ends. The current bit is included in the snapshot. Counters and phase clear, and the next window starts back-to-back in the following cycle, reloading osr_eff if en=1.
  - en=0 in INTEG: abort the window. No snapshot; counters clear; return to IDLE. A drain already in progress continues.
- Counter width OSR_W+1, so the count range is 0..osr_eff with no wrap.
- Conversion: sample = cnt - (osr_eff >> 1), computed at OSR_W+2 bits signed. Examples: osr 100, all ones -> +50; all zeros -> -50.
- Snapshot: at window end, if no drain is pending, all NCH converted samples are copied to hold registers and the output FSM starts.
- Output FSM: IDLE -> SEND.
  - SEND presents channels 0..NCH-1 in order.
  - Advance on out_valid & out_ready.
  - After the beat with out_last=1 is accepted, return to IDLE.
- Overrun: if a window ends while SEND is still active, the new snapshot is discarded, the hold registers are unchanged, and overrun is set to 1.

## Timing
- Reset values: out_valid 0, out_data 0, out_chan 0, out_last 0, overrun 0; both FSMs in IDLE; all counters 0.
- First window starts the cycle after en is sampled high. A window spans exactly osr_eff comp_out samples.
- Latency: out_valid rises 1 clk after the cycle carrying the last bit of the window.
- Handshake:
  - Once out_valid is high, out_data, out_chan and out_last stay stable until accepted.
  - out_valid must not depend combinationally on out_ready.
  - With out_ready held at 1, the block produces one beat per clk, so a drain takes NCH cycles.
- Minimum overrun-free window with out_ready=1: osr_eff >= NCH.
- Window end in the same cycle the final beat is accepted: the snapshot is taken with no overrun, and out_valid stays high the next cycle with channel 0.
- Reset asserted mid-window or mid-drain: all state returns to reset values immediately; no beat is completed.

## Configuration
- DS_ADC_DECIM_SAT_EN defined: when a sample exceeds the signed WIDTH range, out_data saturates to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
- DS_ADC_DECIM_SAT_EN undefined: out_data is the low WIDTH bits of the sample (two's-complement wrap). No range logic is present.

## Test plan
- NCH=2, WIDTH=8, osr=100, ch0 all ones, ch1 all zeros, out_ready=1 -> beats (chan0, +50), then (chan1, -50, last=1); first out_valid 101 clk after en.
- osr=10, ch0 pattern 1,1,0 repeating -> counts alternate across consecutive windows; each window outputs cnt-5 for ch0, with back-to-back windows and no gap cycles.
- out_ready=0 for 2 full windows (osr=4) -> out_valid stays high with the first window's data, the second window is dropped, overrun=1, and the first data is intact when finally accepted.
- en dropped at phase 37 of osr=100 -> no beat is produced; en raised again -> the next window's count starts from 0.
- osr=0 and osr=1 -> each window spans 2 cycles; all-ones input yields +1 per channel.
- osr=255, all ones, WIDTH=6 -> out_data = +31 with DS_ADC_DECIM_SAT_EN defined, and the wrapped value 0b000000 (128 mod 64 = 0) without it.
